// File: rtl/uart_tx_arbiter.sv
// -----------------------------------------------------------------------------
// uart_tx_arbiter
//
// Shares one UART byte transmitter among NUM_REQ requesters. A round-robin
// search picks one pending requester, latches its byte and issues a single-cycle
// start. The arbiter then follows the transmitter's busy flag through the
// frame. If busy never rises within ACCEPT_TO cycles, it gives up with a
// timeout pulse.
//
// Ports:
//   clk          system clock, rising edge
//   rst          synchronous active-high reset
//   req          per-requester request level
//   req_data     requester i's byte at [i*DATA_W +: DATA_W]
//   ack          one-hot, one-cycle "byte latched" pulse (during ISSUE)
//   tx_start     one-cycle start pulse to the transmitter (during ISSUE)
//   tx_data      latched byte, held from grant until the next grant
//   tx_busy      transmitter frame in progress
//   active_id    index of the last granted requester
//   err_timeout  one-cycle pulse in the first IDLE cycle after a timeout
//   idle         high while the FSM is in IDLE
// -----------------------------------------------------------------------------
module uart_tx_arbiter #(
   parameter int NUM_REQ   = 4,
   parameter int DATA_W    = 8,
   parameter int ACCEPT_TO = 16
) (
   input  logic                        clk,
   input  logic                        rst,
   input  logic [NUM_REQ-1:0]          req,
   input  logic [NUM_REQ*DATA_W-1:0]   req_data,
   output logic [NUM_REQ-1:0]          ack,
   output logic                        tx_start,
   output logic [DATA_W-1:0]           tx_data,
   input  logic                        tx_busy,
   output logic [$clog2(NUM_REQ)-1:0]  active_id,
   output logic                        err_timeout,
   output logic                        idle
);

   localparam int ID_W  = $clog2(NUM_REQ);
   localparam int CNT_W = $clog2(ACCEPT_TO) + 1;

   typedef enum logic [1:0] {
      ST_IDLE        = 2'd0,
      ST_ISSUE       = 2'd1,
      ST_WAIT_ACCEPT = 2'd2,
      ST_WAIT_DONE   = 2'd3
   } state_t;

   state_t              state_r;
   logic [ID_W-1:0]     rr_ptr_r;
   logic [CNT_W-1:0]    cnt_r;
   logic [NUM_REQ-1:0]  ack_r;
   logic                tx_start_r;
   logic [DATA_W-1:0]   tx_data_r;
   logic [ID_W-1:0]     active_id_r;
   logic                err_timeout_r;

   logic                grant_s;
   logic [ID_W-1:0]     win_id_s;
   logic [ID_W-1:0]     next_ptr_s;

   // Round-robin winner search: scan from rr_ptr upward with wrap. The loop runs
   // from the farthest candidate back to rr_ptr so the nearest set bit wins.
   always_comb begin
      win_id_s = '0;
      for (int k = NUM_REQ - 1; k >= 0; k--) begin
         win_id_s = req[(int'(rr_ptr_r) + k) % NUM_REQ]
                    ? ID_W'((int'(rr_ptr_r) + k) % NUM_REQ)
                    : win_id_s;
      end
   end

   // Grant qualification and the pointer value that follows the winner.
   always_comb begin
      grant_s = (|req) & ~tx_busy;
      if (win_id_s == ID_W'(NUM_REQ - 1)) begin
         next_ptr_s = '0;
      end else begin
         next_ptr_s = win_id_s + {{(ID_W-1){1'b0}}, 1'b1};
      end
   end

   // Arbiter FSM. All outputs are registered here, so req has no combinational
   // path to ack. ack and tx_start are set on the grant edge, so they are
   // high exactly during the ISSUE cycle.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_r       <= ST_IDLE;
         rr_ptr_r      <= '0;
         cnt_r         <= '0;
         ack_r         <= '0;
         tx_start_r    <= 1'b0;
         tx_data_r     <= '0;
         active_id_r   <= '0;
         err_timeout_r <= 1'b0;
      end else begin
         ack_r         <= '0;
         tx_start_r    <= 1'b0;
         err_timeout_r <= 1'b0;
         case (state_r)
            ST_IDLE: begin
               if (grant_s) begin
                  tx_data_r   <= req_data[win_id_s*DATA_W +: DATA_W];
                  active_id_r <= win_id_s;
                  rr_ptr_r    <= next_ptr_s;
                  ack_r       <= {{(NUM_REQ-1){1'b0}}, 1'b1} << win_id_s;
                  tx_start_r  <= 1'b1;
                  state_r     <= ST_ISSUE;
               end else begin
                  state_r <= ST_IDLE;
               end
            end
            ST_ISSUE: begin
               cnt_r   <= '0;
               state_r <= ST_WAIT_ACCEPT;
            end
            ST_WAIT_ACCEPT: begin
               if (tx_busy) begin
                  state_r <= ST_WAIT_DONE;
               end else if (cnt_r == CNT_W'(ACCEPT_TO - 1)) begin
                  // The requester does not get its turn back after a timeout.
                  err_timeout_r <= 1'b1;
                  state_r       <= ST_IDLE;
               end else begin
                  cnt_r <= cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
               end
            end
            ST_WAIT_DONE: begin
               if (!tx_busy) begin
                  state_r <= ST_IDLE;
               end else begin
                  state_r <= ST_WAIT_DONE;
               end
            end
            default: begin
               state_r <= ST_IDLE;
            end
         endcase
      end
   end

   assign ack         = ack_r;
   assign tx_start    = tx_start_r;
   assign tx_data     = tx_data_r;
   assign active_id   = active_id_r;
   assign err_timeout = err_timeout_r;
   assign idle        = (state_r == ST_IDLE);

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// -----------------------------------------------------------------------------
// tb_uart_tx_arbiter
//
// Directed and randomized bench for uart_tx_arbiter. Each frame is predicted
// at transaction level from the arbiter's rules:
//   - the winner is the first requester at or after the round-robin pointer;
//   - the frame is accepted if busy rises within ACCEPT_TO wait cycles;
//   - idle comes back one cycle after busy falls;
//   - otherwise err_timeout pulses in the first idle cycle.
// Each frame is then checked cycle by cycle.
// -----------------------------------------------------------------------------
module tb_uart_tx_arbiter;

   localparam int NR   = 4;
   localparam int DW   = 8;
   localparam int AT   = 16;
   localparam int ID_W = $clog2(NR);

   logic                 clk = 1'b0;
   logic                 rst = 1'b1;
   logic [NR-1:0]        req = '0;
   logic [NR*DW-1:0]     req_data = '0;
   logic [NR-1:0]        ack;
   logic                 tx_start;
   logic [DW-1:0]        tx_data;
   logic                 tx_busy = 1'b0;
   logic [ID_W-1:0]      active_id;
   logic                 err_timeout;
   logic                 idle;

   int total  = 0;
   int passes = 0;

   // Reference-model state: round-robin pointer, last latched byte, last id.
   int            rr_m   = 0;
   logic [DW-1:0] data_m = '0;
   int            id_m   = 0;

   uart_tx_arbiter #(.NUM_REQ(NR), .DATA_W(DW), .ACCEPT_TO(AT)) dut (
      .clk(clk), .rst(rst), .req(req), .req_data(req_data), .ack(ack),
      .tx_start(tx_start), .tx_data(tx_data), .tx_busy(tx_busy),
      .active_id(active_id), .err_timeout(err_timeout), .idle(idle)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) passes++;
      else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
   endtask

   // The first requester with a set request bit, searching from ptr with wrap.
   function automatic int pick(input logic [NR-1:0] r, input int ptr);
      for (int k = 0; k < NR; k++) begin
         if (r[(ptr + k) % NR]) return (ptr + k) % NR;
      end
      return -1;
   endfunction

   task automatic check_reset_values(input string tag);
      chk({tag, "_ack"},      ack,         0);
      chk({tag, "_start"},    tx_start,    0);
      chk({tag, "_data"},     tx_data,     0);
      chk({tag, "_id"},       active_id,   0);
      chk({tag, "_err"},      err_timeout, 0);
      chk({tag, "_idle"},     idle,        1);
   endtask

   task automatic do_reset();
      rst = 1'b1; req = '0; tx_busy = 1'b0;
      tick();
      tick();
      check_reset_values("reset");
      rst = 1'b0;
      rr_m = 0; data_m = '0; id_m = 0;
   endtask

   // One arbitration.
   //   r      : request vector presented in IDLE
   //   delay  : busy stays low for this many wait cycles before rising
   //            (delay >= AT means busy never rises)
   //   len    : number of cycles busy stays high
   //   rst_at : frame cycle (0 = ISSUE) in which rst is asserted, -1 for none
   task automatic frame(input logic [NR-1:0] r, input int delay, input int len,
                        input int rst_at);
      int            w;
      logic [DW-1:0] d;
      bit            acc;
      bit            is_end;
      int            c0;
      int            end_c;
      w      = pick(r, rr_m);
      d      = req_data[w*DW +: DW];
      acc    = (delay < AT);
      c0     = 1 + delay;
      end_c  = acc ? (c0 + len + 1) : (AT + 1);
      req     = r;
      tx_busy = 1'b0;
      tick();
      rr_m = (w + 1) % NR; data_m = d; id_m = w;
      for (int c = 0; c <= end_c; c++) begin
         is_end  = (c == end_c);
         tx_busy = acc && (c >= c0) && (c < c0 + len);
         // Requests and data outside IDLE must be ignored; scramble them.
         req      = is_end ? '0 : NR'($urandom);
         req_data = is_end ? req_data : $urandom;
         rst      = (c == rst_at);
         chk("ack",      ack,         (c == 0) ? (32'd1 << w) : 32'd0);
         chk("tx_start", tx_start,    (c == 0) ? 32'd1 : 32'd0);
         chk("tx_data",  tx_data,     data_m);
         chk("active_id", active_id,  id_m);
         chk("idle",     idle,        is_end ? 32'd1 : 32'd0);
         chk("err_timeout", err_timeout, (is_end && !acc) ? 32'd1 : 32'd0);
         if (rst) begin
            tick();
            check_reset_values("rst_mid");
            rst = 1'b0; req = '0; tx_busy = 1'b0;
            rr_m = 0; data_m = '0; id_m = 0;
            return;
         end
         if (!is_end) tick();
      end
   endtask

   // tx_busy high in IDLE blocks any grant.
   task automatic blocked(input logic [NR-1:0] r, input int n);
      for (int i = 0; i < n; i++) begin
         req = r; tx_busy = 1'b1;
         tick();
         chk("blk_ack",   ack,      0);
         chk("blk_start", tx_start, 0);
         chk("blk_idle",  idle,     1);
      end
   endtask

   initial begin
      // Reset state
      do_reset();

      // Single requester: byte 0x41, busy for 10 cycles starting 1 after start
      req_data = 32'h1122_3341;
      frame(4'b0001, 0, 10, -1);

      // Round-robin fairness from a fresh pointer: expect 0,1,2,3,0,1
      do_reset();
      for (int i = 0; i < 6; i++) begin
         req_data = $urandom;
         frame(4'b1111, i % 3, 1 + (i % 2), -1);
      end

      // Grant 2, then 0101 -> 0 (search wraps from 3), then 0101 -> 2
      frame(4'b0100, 0, 1, -1);
      frame(4'b0101, 0, 1, -1);
      frame(4'b0101, 0, 1, -1);

      // Timeout with busy stuck low, then the next requester gets the grant
      req_data = $urandom;
      frame(4'b1111, AT, 1, -1);
      frame(4'b1111, 2, 3, -1);

      // Busy blocking in IDLE
      blocked(4'b0010, 3);
      frame(4'b0010, 0, 2, -1);

      // Reset in WAIT_DONE, then 1111 must go to requester 0
      frame(4'b1011, 0, 10, 4);
      frame(4'b1111, 0, 1, -1);

      // Reset during ISSUE
      frame(4'b0110, 0, 3, 0);
      frame(4'b1111, 1, 1, -1);

      // Randomized frames, including occasional timeouts
      for (int i = 0; i < 40; i++) begin
         req_data = $urandom;
         frame(NR'($urandom_range(1, 15)), $urandom_range(0, AT),
               $urandom_range(1, 5), -1);
      end

      $display("%0d/%0d checks passed", passes, total);
      $finish;
   end

   // Global time bound so the run always ends.
   initial begin
      #200000;
      $display("FAIL watchdog: observed timeout expected completion");
      $fatal(1, "watchdog expired");
   end

endmodule
